player_input_ctrl: RTL and testbench

- Driver side of the player movement command interface. Produces move_enable, move_left, move_right and jump for the player movement block.
- Synchronises and debounces raw board buttons, and resolves left+right conflicts as last-pressed-wins.
- Buffers jump presses and runs an action FSM (idle/attack/stun) that gates movement.
- One instance per player. It sits between the button pins and the movement block, and uses the movement block's jump_active as feedback.

---
 rtl/player_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/player_input_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_player_input_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the player input controller: action state encoding,
// facing-direction encoding and the default frame constants.
package player_pkg;

    // Action FSM encoding, also driven directly onto action_state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_STUN   = 2'd2
    } action_state_t;

    // Most recently pressed horizontal direction.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Default frame constants (counted in SCEN ticks).
    localparam int unsigned DEF_DEBOUNCE_FRAMES    = 2;
    localparam int unsigned DEF_JUMP_BUFFER_FRAMES = 4;
    localparam int unsigned DEF_ATTACK_FRAMES      = 20;
    localparam int unsigned DEF_STUN_FRAMES        = 15;
    localparam int unsigned DEF_CNT_WIDTH          = 5;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser followed by a debouncer that counts SCEN ticks.
// level is the debounced value; rise is high during the SCEN cycle on which the
// debounced value flips from 0 to 1, so frame-rate logic can act on it that tick.
module btn_debounce
    import player_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scen,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_WIDTH-1:0] FlipCnt = CNT_WIDTH'(DEBOUNCE_FRAMES - 1);

    logic [1:0]           sync_q;
    logic                 level_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 differ;
    logic                 flip;

    assign differ = (sync_q[1] != level_q);
    // The SCEN that would bring the count up to DEBOUNCE_FRAMES flips the level.
    assign flip   = scen && differ && (cnt_q == FlipCnt);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Count SCEN ticks while the synchronised value disagrees; flip after enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (!differ) begin
            cnt_q <= '0;
        end else if (flip) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
        end else if (scen) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign level = level_q;
    assign rise  = flip && sync_q[1];

endmodule

// File: rtl/player_input_ctrl.sv
// Player input controller: debounces the four buttons, resolves left/right as
// last-pressed-wins, buffers jump requests and runs the idle/attack/stun FSM
// that gates movement commands.
// Build option: define PLAYER_CTRL_AIR_ATTACK_EN to allow attacks while airborne
// (movement stays enabled during an airborne attack so the jump arc completes).
module player_input_ctrl
    import player_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES    = DEF_DEBOUNCE_FRAMES,
    parameter int unsigned JUMP_BUFFER_FRAMES = DEF_JUMP_BUFFER_FRAMES,
    parameter int unsigned ATTACK_FRAMES      = DEF_ATTACK_FRAMES,
    parameter int unsigned STUN_FRAMES        = DEF_STUN_FRAMES,
    parameter int unsigned CNT_WIDTH          = DEF_CNT_WIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       jump_active,
    input  logic       hit_stun,
    output logic       move_enable,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       attack_start,
    output logic [1:0] action_state
);

`ifdef PLAYER_CTRL_AIR_ATTACK_EN
    localparam bit AirAttack = 1'b1;
`else
    localparam bit AirAttack = 1'b0;
`endif

    logic left_lvl, left_rise;
    logic right_lvl, right_rise;
    logic jump_lvl, jump_rise;
    logic attack_lvl, attack_rise;

    action_state_t        state_q;
    logic [CNT_WIDTH-1:0] act_cnt_q;
    logic                 attack_start_q;
    logic                 jump_pend_q;
    logic [CNT_WIDTH-1:0] jump_cnt_q;
    dir_t                 last_dir_q;

    logic in_idle;
    logic attack_ok;
    logic go_attack;
    logic unused_levels;

    btn_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_db_left (
        .clk    (clk),
        .reset_n(reset_n),
        .scen   (SCEN),
        .btn_raw(btn_left),
        .level  (left_lvl),
        .rise   (left_rise)
    );

    btn_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_db_right (
        .clk    (clk),
        .reset_n(reset_n),
        .scen   (SCEN),
        .btn_raw(btn_right),
        .level  (right_lvl),
        .rise   (right_rise)
    );

    btn_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_db_jump (
        .clk    (clk),
        .reset_n(reset_n),
        .scen   (SCEN),
        .btn_raw(btn_jump),
        .level  (jump_lvl),
        .rise   (jump_rise)
    );

    btn_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_db_attack (
        .clk    (clk),
        .reset_n(reset_n),
        .scen   (SCEN),
        .btn_raw(btn_attack),
        .level  (attack_lvl),
        .rise   (attack_rise)
    );

    // Jump and attack act only on their edges; their levels are not needed.
    assign unused_levels = ^{jump_lvl, attack_lvl};

    assign in_idle   = (state_q == ST_IDLE);
    assign attack_ok = attack_rise && (!jump_active || AirAttack);
    // A hit on the same cycle takes priority over starting an attack.
    assign go_attack = SCEN && in_idle && attack_ok && !hit_stun;

    // Action FSM: hit_stun acts on any cycle, everything else on SCEN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            act_cnt_q      <= '0;
            attack_start_q <= 1'b0;
        end else begin
            attack_start_q <= 1'b0;
            if (hit_stun) begin
                state_q   <= ST_STUN;
                act_cnt_q <= CNT_WIDTH'(STUN_FRAMES);
            end else if (SCEN) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (go_attack) begin
                            state_q        <= ST_ATTACK;
                            act_cnt_q      <= CNT_WIDTH'(ATTACK_FRAMES);
                            attack_start_q <= 1'b1;
                        end
                    end
                    ST_ATTACK, ST_STUN: begin
                        if (act_cnt_q <= CNT_WIDTH'(1)) begin
                            state_q   <= ST_IDLE;
                            act_cnt_q <= '0;
                        end else begin
                            act_cnt_q <= act_cnt_q - CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        act_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    // Jump buffer: armed by a debounced edge in IDLE, dropped on use or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jump_pend_q <= 1'b0;
            jump_cnt_q  <= '0;
        end else if (hit_stun || go_attack) begin
            jump_pend_q <= 1'b0;
            jump_cnt_q  <= '0;
        end else if (in_idle && jump_rise) begin
            jump_pend_q <= 1'b1;
            jump_cnt_q  <= CNT_WIDTH'(JUMP_BUFFER_FRAMES);
        end else if (SCEN && jump_pend_q) begin
            if (move_enable && !jump_active) begin
                // Movement block takes the jump this frame.
                jump_pend_q <= 1'b0;
                jump_cnt_q  <= '0;
            end else if (jump_cnt_q <= CNT_WIDTH'(1)) begin
                jump_pend_q <= 1'b0;
                jump_cnt_q  <= '0;
            end else begin
                jump_cnt_q <= jump_cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    // Remember the most recent debounced press; right wins a same-tick tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_dir_q <= DIR_LEFT;
        end else if (right_rise) begin
            last_dir_q <= DIR_RIGHT;
        end else if (left_rise) begin
            last_dir_q <= DIR_LEFT;
        end
    end

    // Movement commands, gated so only IDLE can walk or jump.
    always_comb begin
        move_enable = in_idle || (AirAttack && (state_q == ST_ATTACK) && jump_active);
        move_left   = in_idle && left_lvl && (!right_lvl || (last_dir_q == DIR_LEFT));
        move_right  = in_idle && right_lvl && (!left_lvl || (last_dir_q == DIR_RIGHT));
        jump        = in_idle && jump_pend_q;
    end

    assign attack_start = attack_start_q;
    assign action_state = state_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios plus randomized frames, every
// cycle compared against a rule-level reference model.
module tb_player_input_ctrl;

    localparam int DEB = 2;
    localparam int JB  = 4;
    localparam int ATK = 20;
    localparam int STN = 15;
    localparam int FRAME_CYC = 4;
`ifdef PLAYER_CTRL_AIR_ATTACK_EN
    localparam bit AIR = 1'b1;
`else
    localparam bit AIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n, SCEN, btn_left, btn_right, btn_jump, btn_attack, jump_active, hit_stun;
    logic move_enable, move_left, move_right, jump, attack_start;
    logic [1:0] action_state;
    logic [6:0] outv;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEBOUNCE_FRAMES   (DEB),
        .JUMP_BUFFER_FRAMES(JB),
        .ATTACK_FRAMES     (ATK),
        .STUN_FRAMES       (STN),
        .CNT_WIDTH         (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .SCEN        (SCEN),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .btn_attack  (btn_attack),
        .jump_active (jump_active),
        .hit_stun    (hit_stun),
        .move_enable (move_enable),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .attack_start(attack_start),
        .action_state(action_state)
    );

    assign outv = {move_enable, move_left, move_right, jump, attack_start, action_state};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0=left 1=right 2=jump 3=attack) ----
    bit m_s1[4], m_s2[4], m_lvl[4];
    int m_dcnt[4];
    int m_st, m_acnt, m_jcnt;
    bit m_astart, m_pend, m_last_right;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_dcnt[i] = 0;
        end
        m_st = 0; m_acnt = 0; m_jcnt = 0;
        m_astart = 0; m_pend = 0; m_last_right = 0;
    endtask

    function automatic bit model_me(input int st, input bit jact);
        return (st == 0) || (AIR && st == 1 && jact);
    endfunction

    task automatic model_step();
        bit raw[4];
        bit rise[4];
        bit go_atk;
        int old_st;
        raw[0] = btn_left; raw[1] = btn_right; raw[2] = btn_jump; raw[3] = btn_attack;
        for (int i = 0; i < 4; i++)
            rise[i] = SCEN && m_s2[i] && !m_lvl[i] && (m_dcnt[i] + 1 >= DEB);
        old_st = m_st;
        go_atk = !hit_stun && SCEN && old_st == 0 && rise[3] && (!jump_active || AIR);
        // jump buffer, from the state before this edge
        if (hit_stun || go_atk) m_pend = 0;
        else if (old_st == 0 && rise[2]) begin m_pend = 1; m_jcnt = JB; end
        else if (SCEN && m_pend) begin
            if (model_me(old_st, jump_active) && !jump_active) m_pend = 0;
            else begin
                m_jcnt--;
                if (m_jcnt <= 0) m_pend = 0;
            end
        end
        // action state
        m_astart = go_atk;
        if (hit_stun) begin m_st = 2; m_acnt = STN; end
        else if (go_atk) begin m_st = 1; m_acnt = ATK; end
        else if (SCEN && old_st != 0) begin
            m_acnt--;
            if (m_acnt <= 0) begin m_st = 0; m_acnt = 0; end
        end
        if (rise[1]) m_last_right = 1;
        else if (rise[0]) m_last_right = 0;
        // debounce counts SCENs of disagreement, then synchronisers shift
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_lvl[i]) m_dcnt[i] = 0;
            else if (SCEN) begin
                m_dcnt[i]++;
                if (m_dcnt[i] >= DEB) begin m_lvl[i] = m_s2[i]; m_dcnt[i] = 0; end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    function automatic logic [6:0] model_out(input bit jact);
        bit idle, ml, mr;
        idle = (m_st == 0);
        ml = idle && m_lvl[0] && (!m_lvl[1] || !m_last_right);
        mr = idle && m_lvl[1] && (!m_lvl[0] || m_last_right);
        return {model_me(m_st, jact), ml, mr, idle && m_pend, m_astart, 2'(m_st)};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        wait (chk_on);
        forever begin
            @(negedge clk);
            check_eq("cycle", 32'(outv), 32'(model_out(jump_active)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            SCEN = 1'b1;
            tick();
            SCEN = 1'b0;
            repeat (FRAME_CYC - 1) tick();
        end
    endtask

    // Change a button and let it settle through the synchroniser and debouncer.
    task automatic settle();
        tick(); tick();
        frame(DEB);
    endtask

    initial begin
        reset_n = 1'b1; SCEN = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
        btn_attack = 0; jump_active = 0; hit_stun = 0;
        #2 reset_n = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check_eq("rst_outs", 32'(outv), 32'h40);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Right held for a single SCEN must not register.
        btn_right = 1; tick(); tick(); frame(1);
        btn_right = 0; tick(); tick(); tick(); frame(2);
        check_eq("right_1scen", 32'(move_right), 32'd0);
        // Held for two SCENs: visible the cycle after the second.
        btn_right = 1; tick(); tick(); frame(1);
        SCEN = 1;
        @(negedge clk);
        check_eq("right_pre", 32'(move_right), 32'd0);
        tick();
        SCEN = 0;
        @(negedge clk);
        check_eq("right_2scen", 32'(move_right), 32'd1);
        tick(); tick();

        // Last-pressed-wins.
        btn_right = 0; settle();
        btn_left = 1; settle();
        check_eq("lr_left", 32'({move_left, move_right}), 32'b10);
        frame(3);
        btn_right = 1; settle();
        check_eq("lr_right_wins", 32'({move_left, move_right}), 32'b01);
        btn_right = 0; settle();
        check_eq("lr_release", 32'({move_left, move_right}), 32'b10);
        btn_left = 0; settle();
        check_eq("lr_none", 32'({move_left, move_right}), 32'b00);

        // Jump buffered over 3 airborne frames, consumed on the 4th SCEN.
        jump_active = 1; btn_jump = 1; settle();
        check_eq("jbuf_held", 32'(jump), 32'd1);
        frame(3);
        check_eq("jbuf_held3", 32'(jump), 32'd1);
        jump_active = 0; frame(1);
        check_eq("jbuf_consumed", 32'(jump), 32'd0);
        btn_jump = 0; settle();
        // Six airborne frames: dropped after 4 SCENs.
        jump_active = 1; btn_jump = 1; settle();
        frame(3);
        check_eq("jdrop_held", 32'(jump), 32'd1);
        frame(1);
        check_eq("jdrop_gone", 32'(jump), 32'd0);
        frame(2); jump_active = 0; frame(1);
        check_eq("jdrop_never", 32'(jump), 32'd0);
        btn_jump = 0; settle();

        // Ground attack.
        btn_attack = 1; tick(); tick(); frame(1);
        SCEN = 1; tick(); SCEN = 0;
        @(negedge clk);
        check_eq("atk_pulse", 32'(attack_start), 32'd1);
        check_eq("atk_state", 32'(action_state), 32'd1);
        check_eq("atk_me", 32'(move_enable), 32'd0);
        tick();
        @(negedge clk);
        check_eq("atk_pulse_end", 32'(attack_start), 32'd0);
        tick(); tick();
        frame(ATK - 1);
        check_eq("atk_19", 32'(action_state), 32'd1);
        frame(1);
        check_eq("atk_done", 32'({move_enable, action_state}), 32'b100);
        btn_attack = 0; settle();

        // Airborne attack edge.
        jump_active = 1; btn_attack = 1; settle();
        check_eq("air_atk", 32'(action_state), AIR ? 32'd1 : 32'd0);
        check_eq("air_me", 32'(move_enable), 32'd1);
        frame(ATK);
        check_eq("air_done", 32'(action_state), 32'd0);
        jump_active = 0; btn_attack = 0; settle();

        // Hit at attack frame 10, re-hit at stun frame 7.
        btn_attack = 1; settle();
        frame(9);
        hit_stun = 1; tick(); hit_stun = 0;
        @(negedge clk);
        check_eq("stun_entry", 32'({attack_start, action_state}), 32'b010);
        frame(7);
        hit_stun = 1; tick(); hit_stun = 0;
        frame(STN - 1);
        check_eq("stun_hold", 32'(action_state), 32'd2);
        frame(1);
        check_eq("stun_done", 32'(action_state), 32'd0);
        btn_attack = 0; settle();

        // Hit and attack edge on the same SCEN.
        btn_attack = 1; tick(); tick(); frame(1);
        SCEN = 1; hit_stun = 1; tick(); SCEN = 0; hit_stun = 0;
        @(negedge clk);
        check_eq("stun_vs_atk", 32'({attack_start, action_state}), 32'b010);
        frame(3);

        // Asynchronous reset mid-stun.
        reset_n = 0; btn_attack = 0;
        #2;
        check_eq("rst_async", 32'(outv), 32'h40);
        tick(); tick();
        reset_n = 1;
        tick();

        // Randomized frames.
        for (int f = 0; f < 600; f++) begin
            int len;
            len = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 3) == 0) btn_jump = ~btn_jump;
            if ($urandom_range(0, 4) == 0) btn_attack = ~btn_attack;
            if ($urandom_range(0, 2) == 0) jump_active = ~jump_active;
            for (int c = 0; c < len; c++) begin
                SCEN = (c == 0);
                hit_stun = ($urandom_range(0, 79) == 0);
                tick();
            end
            SCEN = 0; hit_stun = 0;
        end
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
